memory_access: RTL and testbench



---
 rtl/memory_access_pkg.sv | 93 +++++++++
 rtl/memory_access_if.sv | 13 +
 rtl/memory_access_memalign.sv | 52 +++++
 rtl/memory_access.sv | 138 +++++++++++++
 tb/tb_memory_access.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// Purpose : shared types for the memory-access pipeline stage: execute/memory
//           stage records, control fields, data-bus request/response and the
//           stage FSM encoding, plus two small helpers.
// Contents: msize_t, control_t, execute_data_t, memory_data_t, dbus_req_t,
//           dbus_resp_t, state_t, is_aligned(), pass_fields().
package memory_access_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   memunsigned;
  } control_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    control_t    ctl;
    logic [63:0] aluout;
    logic [63:0] memwd;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    control_t    ctl;
    logic [63:0] result;
    logic        misalign;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  // An access is aligned when the byte offset is a multiple of its size.
  function automatic logic is_aligned(input logic [2:0] off, input msize_t sz);
    case (sz)
      MSIZE1:  return 1'b1;
      MSIZE2:  return (off[0] == 1'b0);
      MSIZE4:  return (off[1:0] == 2'b00);
      default: return (off == 3'b000);
    endcase
  endfunction

  // Builds a valid memory-stage record from the instruction identity fields.
  function automatic memory_data_t pass_fields(
    input logic [63:0] pc,
    input logic [31:0] raw_instr,
    input logic [4:0]  dst,
    input control_t    ctl,
    input logic [63:0] result,
    input logic        misalign
  );
    memory_data_t m;
    m.valid     = 1'b1;
    m.pc        = pc;
    m.raw_instr = raw_instr;
    m.dst       = dst;
    m.ctl       = ctl;
    m.result    = result;
    m.misalign  = misalign;
    return m;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Purpose : data-bus interface between the memory-access stage (master) and
//           the memory slave.
// Signals : dreq  - request from the stage (valid, addr, size, strobe, data)
//           dresp - response from the slave (addr_ok, data_ok, data)
interface memory_access_if;
  import memory_access_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input  dresp);
  modport slave  (input  dreq, output dresp);
endinterface

// File: rtl/memory_access_memalign.sv
// Purpose : combinational byte-lane alignment for the data bus.
// Ports   : i_offset   - address bits [2:0]
//           i_msize    - access size
//           i_unsigned - zero-extend loads instead of sign-extending
//           i_wdata    - store data, right-justified
//           i_rdata    - raw 64-bit bus read data
//           o_strobe   - byte enables for the store lanes
//           o_wdata    - store data moved onto its byte lanes
//           o_rdata    - load data right-justified and extended
module memory_access_memalign
  import memory_access_pkg::*;
(
  input  logic [2:0]  i_offset,
  input  msize_t      i_msize,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_strobe,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [5:0]  w_shift;
  logic [63:0] w_rshifted;
  logic [3:0]  w_nbytes;

  assign w_shift    = {i_offset, 3'b000};
  assign w_rshifted = i_rdata >> w_shift;
  assign o_wdata    = i_wdata << w_shift;
  assign w_nbytes   = 4'd1 << i_msize;

  // A lane is enabled when it falls in [offset, offset+size); lanes past
  // byte 7 simply drop off, matching a truncated left shift of the mask.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_strobe
      assign o_strobe[gi] = (4'(gi) >= {1'b0, i_offset}) &&
                            (4'(gi) <  ({1'b0, i_offset} + w_nbytes));
    end
  endgenerate

  always_comb begin
    o_rdata = w_rshifted;
    case (i_msize)
      MSIZE1: o_rdata = {{56{w_rshifted[7]  & ~i_unsigned}}, w_rshifted[7:0]};
      MSIZE2: o_rdata = {{48{w_rshifted[15] & ~i_unsigned}}, w_rshifted[15:0]};
      MSIZE4: o_rdata = {{32{w_rshifted[31] & ~i_unsigned}}, w_rshifted[31:0]};
      default: o_rdata = w_rshifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Purpose : memory-access pipeline stage. Passes non-memory instructions to
//           writeback with one cycle of latency, runs one data-bus
//           transaction per load/store and holds upstream while it is open.
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous active-low reset
//           dataE    - execute-stage record
//           in_valid - dataE carries a new instruction this cycle
//           flush    - discard the in-flight instruction
//           busy     - upstream must hold dataE
//           dataM    - registered result towards writeback
//           dbus     - data-bus master port (dreq out, dresp in)
module memory_access
  import memory_access_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int BUS_BYTES   = 8      // only 8 is supported
) (
  input  logic                   clk,
  input  logic                   reset,
  input  execute_data_t          dataE,
  input  logic                   in_valid,
  input  logic                   flush,
  output logic                   busy,
  output memory_data_t           dataM,
  memory_access_if.master        dbus
);

  state_t        r_state, w_state_next;
  execute_data_t r_hold,  w_hold_next;
  memory_data_t  r_datam, w_datam_next;

  logic        w_accept;
  logic        w_mem_op;
  logic        w_complete;
  logic [7:0]  w_strobe;
  logic [63:0] w_wdata;
  logic [63:0] w_rdata;

  assign w_accept = in_valid && dataE.valid && !flush;
  assign w_mem_op = dataE.ctl.memread || dataE.ctl.memwrite;
  assign dataM    = r_datam;

  // Alignment always works on the held instruction: the bus is only driven
  // from REQ/WAIT_DATA, where r_hold is the instruction in flight.
  memory_access_memalign u_memalign (
    .i_offset   (r_hold.aluout[2:0]),
    .i_msize    (r_hold.ctl.msize),
    .i_unsigned (r_hold.ctl.memunsigned),
    .i_wdata    (r_hold.memwd),
    .i_rdata    (dbus.dresp.data),
    .o_strobe   (w_strobe),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_datam <= '0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_datam <= w_datam_next;
    end
  end

  // r_hold.valid doubles as the "keep result" flag: a flush after the bus
  // accepted the request clears it, so the data still arrives but is dropped.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_datam_next = '0;
    w_complete   = 1'b0;
    busy         = 1'b0;
    dbus.dreq    = '0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_mem_op) begin
            w_datam_next = pass_fields(dataE.pc, dataE.raw_instr, dataE.dst,
                                       dataE.ctl, dataE.aluout, 1'b0);
          end else if (ALIGN_CHECK &&
                       !is_aligned(dataE.aluout[2:0], dataE.ctl.msize)) begin
            w_datam_next = pass_fields(dataE.pc, dataE.raw_instr, dataE.dst,
                                       dataE.ctl, dataE.aluout, 1'b1);
          end else begin
            w_hold_next  = dataE;
            w_state_next = REQ;
          end
        end
      end

      REQ: begin
        busy             = 1'b1;
        dbus.dreq.valid  = 1'b1;
        dbus.dreq.addr   = r_hold.aluout & ~(64'(BUS_BYTES) - 64'd1);
        dbus.dreq.size   = {1'b0, r_hold.ctl.msize};
        dbus.dreq.strobe = r_hold.ctl.memwrite ? w_strobe : 8'h00;
        dbus.dreq.data   = r_hold.ctl.memwrite ? w_wdata  : 64'h0;
        if (dbus.dresp.addr_ok) begin
          if (dbus.dresp.data_ok) begin
            w_complete = 1'b1;
          end else begin
            w_state_next = WAIT_DATA;
            if (flush) w_hold_next.valid = 1'b0;
          end
        end else if (flush) begin
          // Not yet accepted by the slave, so it is safe to withdraw.
          w_state_next = IDLE;
        end
      end

      WAIT_DATA: begin
        busy = 1'b1;
        if (dbus.dresp.data_ok) begin
          w_complete = 1'b1;
        end else if (flush) begin
          w_hold_next.valid = 1'b0;
        end
      end

      default: w_state_next = IDLE;
    endcase

    if (w_complete) begin
      w_state_next = IDLE;
      if (r_hold.valid && !flush) begin
        w_datam_next = pass_fields(r_hold.pc, r_hold.raw_instr, r_hold.dst,
                                   r_hold.ctl,
                                   r_hold.ctl.memread ? w_rdata : r_hold.aluout,
                                   1'b0);
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          in_valid;
  logic          flush;
  logic          busy;
  memory_data_t  dataM;

  memory_access_if dbus();

  memory_access #(.ALIGN_CHECK(1'b1), .BUS_BYTES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .dataE    (dataE),
    .in_valid (in_valid),
    .flush    (flush),
    .busy     (busy),
    .dataM    (dataM),
    .dbus     (dbus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_seen  = 0;
  memory_data_t exp_q[$];
  memory_data_t mon_exp;

  // Scoreboard: every valid dataM beat pops one expected record.
  always @(negedge clk) begin
    if (reset === 1'b1 && dataM.valid === 1'b1) begin
      n_seen++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got pc=%h result=%h, required no output",
                 dataM.pc, dataM.result);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dataM !== mon_exp)
          $display("FAIL sb_data: got pc=%h result=%h misalign=%b, required pc=%h result=%h misalign=%b",
                   dataM.pc, dataM.result, dataM.misalign,
                   mon_exp.pc, mon_exp.result, mon_exp.misalign);
        else begin
          n_pass++;
          $display("txn pc=%h result=%h misalign=%b", dataM.pc, dataM.result, dataM.misalign);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  function automatic execute_data_t mk(input logic [63:0] pc, input logic rd, input logic wr,
                                       input msize_t sz, input logic uns,
                                       input logic [63:0] alu, input logic [63:0] wd);
    execute_data_t e;
    e = '0;
    e.valid           = 1'b1;
    e.pc              = pc;
    e.raw_instr       = pc[31:0] ^ 32'h0000_0013;
    e.dst             = pc[6:2];
    e.ctl.regwrite    = ~wr;
    e.ctl.memread     = rd;
    e.ctl.memwrite    = wr;
    e.ctl.msize       = sz;
    e.ctl.memunsigned = uns;
    e.aluout          = alu;
    e.memwd           = wd;
    return e;
  endfunction

  function automatic memory_data_t exp_of(input execute_data_t e, input logic [63:0] res,
                                          input logic mis);
    memory_data_t m;
    m.valid = 1'b1; m.pc = e.pc; m.raw_instr = e.raw_instr; m.dst = e.dst;
    m.ctl = e.ctl; m.result = res; m.misalign = mis;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction and plays the bus slave. Cycle k=0 is the first
  // cycle after the accepting edge; a negative index means "never".
  task automatic bus_op(input execute_data_t e, input int ack_at, input int data_at,
                        input int flush_at, input logic [63:0] rdata,
                        output int busy_cnt, output int vreq_cnt, output dbus_req_t first_req);
    int last;
    busy_cnt = 0; vreq_cnt = 0; first_req = '0;
    dataE = e; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    last = ack_at;
    if (data_at > last) last = data_at;
    if (flush_at > last) last = flush_at;
    last = last + 3;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (dbus.dreq.valid === 1'b1) vreq_cnt++;
      if (k == 0) first_req = dbus.dreq;
      dbus.dresp.addr_ok = (k == ack_at);
      dbus.dresp.data_ok = (k == data_at);
      dbus.dresp.data    = (k == data_at) ? rdata : 64'h0;
      flush = (k == flush_at);
      tick();
      dbus.dresp = '0;
      flush = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; dataE = '0; dbus.dresp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (dbus.dreq !== '0) $display("FAIL rst_dreq: got valid=%b addr=%h, required all zero", dbus.dreq.valid, dbus.dreq.addr); else n_pass++;
    n_total++; if (dataM !== '0) $display("FAIL rst_datam: got valid=%b result=%h, required all zero", dataM.valid, dataM.result); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %b, required 0", busy); else n_pass++;
    tick();
  endtask

  task automatic test_alu();
    execute_data_t e; int b, v, n0; dbus_req_t r;
    n0 = n_seen;
    e = mk(64'h100, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h5, 64'h0);
    exp_q.push_back(exp_of(e, 64'h5, 1'b0));
    bus_op(e, -1, -1, -1, 64'h0, b, v, r);
    n_total++; if (v !== 0) $display("FAIL alu_no_dreq: got %0d valid cycles, required 0", v); else n_pass++;
    n_total++; if (b !== 0) $display("FAIL alu_busy: got %0d busy cycles, required 0", b); else n_pass++;
    n_total++; if (n_seen - n0 !== 1) $display("FAIL alu_count: got %0d outputs, required 1", n_seen - n0); else n_pass++;
  endtask

  task automatic test_load_byte();
    execute_data_t e; int b, v, n0; dbus_req_t r;
    n0 = n_seen;
    e = mk(64'h104, 1'b1, 1'b0, MSIZE1, 1'b0, 64'h1003, 64'h0);
    exp_q.push_back(exp_of(e, 64'hFFFF_FFFF_FFFF_FF80, 1'b0));
    bus_op(e, 3, 3, -1, 64'h0000_0000_8000_0000, b, v, r);
    n_total++; if (r.valid !== 1'b1) $display("FAIL lb_valid: got %b, required 1", r.valid); else n_pass++;
    n_total++; if (r.addr !== 64'h1000) $display("FAIL lb_addr: got %h, required 1000", r.addr); else n_pass++;
    n_total++; if (r.size !== 3'd0) $display("FAIL lb_size: got %0d, required 0", r.size); else n_pass++;
    n_total++; if (b !== 4) $display("FAIL lb_busy: got %0d busy cycles, required 4", b); else n_pass++;
    n_total++; if (n_seen - n0 !== 1) $display("FAIL lb_count: got %0d outputs, required 1", n_seen - n0); else n_pass++;
  endtask

  task automatic test_store_half();
    execute_data_t e; int b, v, n0; dbus_req_t r;
    n0 = n_seen;
    e = mk(64'h108, 1'b0, 1'b1, MSIZE2, 1'b0, 64'h2002, 64'hBEEF);
    exp_q.push_back(exp_of(e, 64'h2002, 1'b0));
    bus_op(e, 1, 1, -1, 64'h0, b, v, r);
    n_total++; if (r.strobe !== 8'h0C) $display("FAIL sh_strobe: got %h, required 0c", r.strobe); else n_pass++;
    n_total++; if (r.data !== 64'h0000_0000_BEEF_0000) $display("FAIL sh_data: got %h, required 00000000beef0000", r.data); else n_pass++;
    n_total++; if (r.addr !== 64'h2000) $display("FAIL sh_addr: got %h, required 2000", r.addr); else n_pass++;
    n_total++; if (b !== 2) $display("FAIL sh_busy: got %0d, required 2", b); else n_pass++;
    n_total++; if (n_seen - n0 !== 1) $display("FAIL sh_count: got %0d outputs, required 1", n_seen - n0); else n_pass++;
  endtask

  task automatic test_access_table();
    logic [63:0] alu [3] = '{64'h4006, 64'h5004, 64'h6000};
    msize_t      sz  [3] = '{MSIZE2, MSIZE4, MSIZE8};
    logic        uns [3] = '{1'b1, 1'b0, 1'b0};
    logic        wr  [3] = '{1'b0, 1'b0, 1'b1};
    logic [63:0] rd  [3] = '{64'hABCD_0000_0000_0000, 64'h8765_4321_0000_0000, 64'h0};
    logic [63:0] res [3] = '{64'hABCD, 64'hFFFF_FFFF_8765_4321, 64'h6000};
    int          ack [3] = '{0, 0, 1};
    int          dat [3] = '{0, 2, 1};
    execute_data_t e; int b, v, n0; dbus_req_t r;
    for (int i = 0; i < 3; i++) begin
      n0 = n_seen;
      e = mk(64'h200 + 64'(i * 4), ~wr[i], wr[i], sz[i], uns[i], alu[i], 64'h1122_3344_5566_7788);
      exp_q.push_back(exp_of(e, res[i], 1'b0));
      bus_op(e, ack[i], dat[i], -1, rd[i], b, v, r);
      n_total++; if (b !== dat[i] + 1) $display("FAIL tbl%0d_busy: got %0d, required %0d", i, b, dat[i] + 1); else n_pass++;
      n_total++; if (n_seen - n0 !== 1) $display("FAIL tbl%0d_count: got %0d, required 1", i, n_seen - n0); else n_pass++;
      if (wr[i]) begin
        n_total++; if (r.strobe !== 8'hFF || r.data !== 64'h1122_3344_5566_7788)
          $display("FAIL tbl%0d_store: got strobe=%h data=%h, required ff 1122334455667788", i, r.strobe, r.data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_misalign();
    execute_data_t e; int b, v, n0; dbus_req_t r;
    n0 = n_seen;
    e = mk(64'h300, 1'b1, 1'b0, MSIZE4, 1'b0, 64'h3002, 64'h0);
    exp_q.push_back(exp_of(e, 64'h3002, 1'b1));
    bus_op(e, -1, -1, -1, 64'h0, b, v, r);
    n_total++; if (v !== 0) $display("FAIL mis_no_dreq: got %0d valid cycles, required 0", v); else n_pass++;
    n_total++; if (n_seen - n0 !== 1) $display("FAIL mis_count: got %0d outputs, required 1", n_seen - n0); else n_pass++;
  endtask

  task automatic test_flush();
    execute_data_t e; int b, v, n0; dbus_req_t r;
    n0 = n_seen;
    e = mk(64'h400, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h7000, 64'h0);
    bus_op(e, 0, 3, 1, 64'hDEAD_BEEF_0000_0001, b, v, r);
    n_total++; if (b !== 4) $display("FAIL flw_busy: got %0d busy cycles, required 4", b); else n_pass++;
    n_total++; if (v !== 1) $display("FAIL flw_dreq: got %0d valid cycles, required 1", v); else n_pass++;
    n_total++; if (n_seen !== n0) $display("FAIL flw_discard: got %0d outputs, required 0", n_seen - n0); else n_pass++;
    e = mk(64'h404, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h7008, 64'h0);
    bus_op(e, -1, -1, 1, 64'h0, b, v, r);
    n_total++; if (b !== 2 || v !== 2) $display("FAIL flr_cycles: got busy=%0d valid=%0d, required 2 2", b, v); else n_pass++;
    n_total++; if (n_seen !== n0) $display("FAIL flr_discard: got %0d outputs, required 0", n_seen - n0); else n_pass++;
    dataE = mk(64'h408, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h9, 64'h0);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) tick();
    n_total++; if (n_seen !== n0) $display("FAIL fli_discard: got %0d outputs, required 0", n_seen - n0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    execute_data_t e1, e2; int n0;
    n0 = n_seen;
    e1 = mk(64'h500, 1'b0, 1'b0, MSIZE8, 1'b0, 64'hAAAA_0000_0000_0001, 64'h0);
    e2 = mk(64'h504, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h0000_5555_0000_0002, 64'h0);
    exp_q.push_back(exp_of(e1, e1.aluout, 1'b0));
    exp_q.push_back(exp_of(e2, e2.aluout, 1'b0));
    dataE = e1; in_valid = 1'b1;
    tick();
    dataE = e2;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_total++; if (n_seen - n0 !== 2) $display("FAIL b2b_count: got %0d outputs, required 2", n_seen - n0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    execute_data_t e; int b, v, n0; dbus_req_t r;
    dataE = mk(64'h600, 1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    dbus.dresp.addr_ok = 1'b1;
    tick();
    dbus.dresp = '0;
    n_total++; if (busy !== 1'b1) $display("FAIL rm_wait_busy: got %b, required 1", busy); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || dbus.dreq.valid !== 1'b0 || dataM.valid !== 1'b0)
      $display("FAIL rm_clear: got busy=%b dreq.valid=%b dataM.valid=%b, required 0 0 0", busy, dbus.dreq.valid, dataM.valid);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    n0 = n_seen;
    e = mk(64'h604, 1'b0, 1'b0, MSIZE8, 1'b0, 64'h77, 64'h0);
    exp_q.push_back(exp_of(e, 64'h77, 1'b0));
    bus_op(e, -1, -1, -1, 64'h0, b, v, r);
    n_total++; if (n_seen - n0 !== 1 || b !== 0) $display("FAIL rm_idle: got outputs=%0d busy=%0d, required 1 0", n_seen - n0, b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_access_table();
    test_misalign();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
